// File: rtl/fp_mini_pkg.sv
// Shared definitions for the 8-bit unsigned mini-float datapath: {exp, man}, value = man * 2^exp.
package fp_mini_pkg;

  localparam int EXP_W = 3;
  localparam int MAN_W = 5;
  localparam int W     = EXP_W + MAN_W;

  localparam logic [W-1:0]     SAT_RESULT = '1;
  localparam logic [MAN_W-1:0] MAN_HALF   = MAN_W'(1) << (MAN_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    ALIGN,
    ADD,
    DONE
  } state_t;

  function automatic logic [EXP_W-1:0] exp_of(input logic [W-1:0] x);
    return x[W-1:MAN_W];
  endfunction

  function automatic logic [MAN_W-1:0] man_of(input logic [W-1:0] x);
    return x[MAN_W-1:0];
  endfunction

endpackage

// File: rtl/fp_normalize.sv
// Combinational carry normalisation, optional round-half-up and exponent saturation.
// Guard-bit rounding is present only when FP_ADD_ROUND_EN is defined.
module fp_normalize
  import fp_mini_pkg::*;
(
  input  logic [MAN_W:0]   s,
  input  logic [EXP_W-1:0] e,
`ifdef FP_ADD_ROUND_EN
  input  logic             g,
`endif
  output logic [W-1:0]     res,
  output logic             ovf
);

  logic [MAN_W-1:0] man;
  logic [EXP_W:0]   exp_x;
`ifdef FP_ADD_ROUND_EN
  logic             gg;
  logic [MAN_W:0]   man_r;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    man   = s[MAN_W-1:0];
    exp_x = {1'b0, e};
    if (s[MAN_W]) begin
      man   = s[MAN_W:1];
      exp_x = {1'b0, e} + (EXP_W+1)'(1);
    end
`ifdef FP_ADD_ROUND_EN
    // After a carry shift the bit dropped from s becomes the new guard.
    gg    = s[MAN_W] ? s[0] : g;
    man_r = {1'b0, man} + (MAN_W+1)'(gg);
    if (man_r[MAN_W]) begin
      man   = MAN_HALF;
      exp_x = exp_x + (EXP_W+1)'(1);
    end else begin
      man = man_r[MAN_W-1:0];
    end
`endif
    ovf = exp_x[EXP_W];
    res = ovf ? SAT_RESULT : {exp_x[EXP_W-1:0], man};
  end

endmodule

// File: rtl/fp_align_add.sv
// Multi-cycle mini-float adder: serial 1-bit alignment of b, add, normalise, valid/ready output.
// Define FP_ADD_ROUND_EN for guard-bit round-half-up; default build truncates.
module fp_align_add
  import fp_mini_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] sum_out,
  output logic         ovf,
  output logic         order_err,
  output logic         out_valid,
  input  logic         out_ready
);

  state_t           state;
  logic [MAN_W-1:0] ma;
  logic [MAN_W-1:0] mb;
  logic [EXP_W-1:0] e;
  logic [EXP_W-1:0] cnt;
`ifdef FP_ADD_ROUND_EN
  logic             g;
`endif

  logic [MAN_W:0]   s;
  logic [W-1:0]     norm_res;
  logic             norm_ovf;
  logic             bad_order;

  assign in_ready  = (state == IDLE);
  assign s         = {1'b0, ma} + {1'b0, mb};
  assign bad_order = exp_of(a_in) < exp_of(b_in);

  fp_normalize u_norm (
    .s   (s),
    .e   (e),
`ifdef FP_ADD_ROUND_EN
    .g   (g),
`endif
    .res (norm_res),
    .ovf (norm_ovf)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ma        <= '0;
      mb        <= '0;
      e         <= '0;
      cnt       <= '0;
      sum_out   <= '0;
      ovf       <= 1'b0;
      order_err <= 1'b0;
      out_valid <= 1'b0;
`ifdef FP_ADD_ROUND_EN
      g         <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            ma        <= man_of(a_in);
            mb        <= man_of(b_in);
            e         <= exp_of(a_in);
            // A contract violation skips alignment but still produces a result.
            cnt       <= bad_order ? '0 : exp_of(a_in) - exp_of(b_in);
            order_err <= bad_order;
`ifdef FP_ADD_ROUND_EN
            g         <= 1'b0;
`endif
            state     <= ALIGN;
          end
        end
        ALIGN: begin
          if (cnt != '0) begin
            mb  <= mb >> 1;
            cnt <= cnt - EXP_W'(1);
`ifdef FP_ADD_ROUND_EN
            g   <= mb[0];
`endif
          end else begin
            state <= ADD;
          end
        end
        ADD: begin
          sum_out   <= norm_res;
          ovf       <= norm_ovf;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_align_add.sv
// Directed self-checking bench for fp_align_add with hand-computed results and latencies.
module tb_fp_align_add;

  logic       clk;
  logic       rst_n;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] sum_out;
  logic       ovf;
  logic       order_err;
  logic       out_valid;
  logic       out_ready;

  int errors;
  int checks;

  fp_align_add dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_in      (a_in),
    .b_in      (b_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum_out   (sum_out),
    .ovf       (ovf),
    .order_err (order_err),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Launch one operation, measure latency to out_valid, optionally stall in DONE, then retire it.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] want_sum, input logic want_ovf,
                        input logic want_oerr, input int want_lat, input int hold);
    int lat;
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    a_in     = a;
    b_in     = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'(want_lat));
    check({tag, ".sum"}, 32'(sum_out), 32'(want_sum));
    check({tag, ".ovf"}, 32'(ovf), 32'(want_ovf));
    check({tag, ".order_err"}, 32'(order_err), 32'(want_oerr));
    for (int i = 0; i < hold; i++) begin
      a_in     = 8'(8'h3C + i);
      b_in     = 8'h21;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, ".hold_sum"}, 32'(sum_out), 32'(want_sum));
      check({tag, ".hold_flags"}, {30'd0, ovf, order_err}, {30'd0, want_ovf, want_oerr});
      check({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, ".retire"}, 32'(out_valid), 32'd0);
  endtask

  logic [7:0] round_want;

  initial begin
    errors    = 0;
    checks    = 0;
    rst_n     = 1'b0;
    a_in      = '0;
    b_in      = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
`ifdef FP_ADD_ROUND_EN
    round_want = 8'b001_00110;
`else
    round_want = 8'b001_00101;
`endif

    #12;
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.sum", 32'(sum_out), 32'd0);
    check("reset.flags", {30'd0, ovf, order_err}, 32'd0);
    check("reset.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op("basic",    8'b101_10000, 8'b011_01000, 8'b101_10010, 1'b0, 1'b0, 4, 0);
    run_op("carry",    8'b010_11000, 8'b010_10000, 8'b011_10100, 1'b0, 1'b0, 2, 0);
    run_op("saturate", 8'b111_11111, 8'b111_00001, 8'hFF,        1'b1, 1'b0, 2, 0);
    run_op("maxshift", 8'b111_00001, 8'b000_11111, 8'b111_00001, 1'b0, 1'b0, 9, 0);
    run_op("backpr",   8'b101_10000, 8'b011_01000, 8'b101_10010, 1'b0, 1'b0, 4, 5);
    run_op("order",    8'b001_01000, 8'b011_00100, 8'b001_01100, 1'b0, 1'b1, 2, 0);
    run_op("clr_oerr", 8'b010_11000, 8'b010_10000, 8'b011_10100, 1'b0, 1'b0, 2, 0);
    run_op("round",    8'b001_00100, 8'b000_00011, round_want,   1'b0, 1'b0, 3, 0);

    // Reset in the middle of a d=5 alignment.
    a_in     = 8'b110_01000;
    b_in     = 8'b001_00100;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst.out_valid", 32'(out_valid), 32'd0);
    check("midrst.sum", 32'(sum_out), 32'd0);
    check("midrst.in_ready", 32'(in_ready), 32'd1);
    repeat (3) @(posedge clk);
    check("midrst.no_output", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_op("after_rst", 8'b101_10000, 8'b011_01000, 8'b101_10010, 1'b0, 1'b0, 4, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
